// File: rtl/prime_power_sequencer.sv
// prime_power_sequencer: walks a prime table and streams the largest power p^k <= B
// of every prime below the bound over a valid/ready handshake.
module prime_power_sequencer #(
  parameter int INDEX_W    = 13,
  parameter int DATA_W     = 9,
  parameter int MAX_INDEX  = 8191,
  parameter int LOOKUP_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  bound,
  input  logic               list_ready,
  output logic [INDEX_W-1:0] list_index,
  input  logic [DATA_W-1:0]  list_data,
  output logic               q_valid,
  output logic [DATA_W-1:0]  q_data,
  input  logic               q_ready,
  output logic               busy,
  output logic               done,
  output logic [INDEX_W-1:0] q_count
);
  localparam int CW = $clog2(LOOKUP_LAT + 1);
  localparam logic [CW-1:0] LAT_RELOAD = CW'(LOOKUP_LAT - 1);
  typedef enum logic [2:0] {IDLE, WAIT_LIST, LOOKUP, POWER, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] bnd_q, bnd_d, p_q, p_d, q_q, q_d, q_data_q, q_data_d;
  logic [INDEX_W-1:0] idx_q, idx_d, count_q, count_d;
  logic [CW-1:0] lat_q, lat_d;
  logic q_valid_q, q_valid_d, done_q, done_d;
  logic [2*DATA_W-1:0] prod;
  // full-width product so an overflowing power is never mistaken for one below the bound
  assign prod = (2*DATA_W)'(q_q) * (2*DATA_W)'(p_q);
  always_comb begin
    state_d   = state_q;
    bnd_d     = bnd_q;
    p_d       = p_q;
    q_d       = q_q;
    q_data_d  = q_data_q;
    idx_d     = idx_q;
    count_d   = count_q;
    lat_d     = lat_q;
    q_valid_d = q_valid_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bnd_d   = bound;
          idx_d   = INDEX_W'(1);
          count_d = '0;
          done_d  = 1'b0;
          state_d = WAIT_LIST;
        end
      end
      WAIT_LIST: begin
        if (list_ready) begin
          lat_d   = LAT_RELOAD;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lat_q != '0) begin
          lat_d = lat_q - CW'(1);
        end else if (list_data == '0 || list_data > bnd_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          p_d     = list_data;
          q_d     = list_data;
          state_d = POWER;
        end
      end
      POWER: begin
        if (prod <= (2*DATA_W)'(bnd_q)) begin
          q_d = prod[DATA_W-1:0];
        end else begin
          q_valid_d = 1'b1;
          q_data_d  = q_q;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (q_ready) begin
          count_d   = count_q + INDEX_W'(1);
          q_valid_d = 1'b0;
          if (idx_q == INDEX_W'(MAX_INDEX)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + INDEX_W'(1);
            lat_d   = LAT_RELOAD;
            state_d = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bnd_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      q_data_q  <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      lat_q     <= '0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bnd_q     <= bnd_d;
      p_q       <= p_d;
      q_q       <= q_d;
      q_data_q  <= q_data_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      lat_q     <= lat_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
    end
  end
  assign list_index = idx_q;
  assign q_valid    = q_valid_q;
  assign q_data     = q_data_q;
  assign busy       = state_q != IDLE && state_q != DONE;
  assign done       = done_q;
  assign q_count    = count_q;
endmodule

// File: tb/tb_prime_power_sequencer.sv
// tb_prime_power_sequencer: table-driven walks against a 30-prime table with a
// one-cycle registered lookup, plus directed timing, stall, restart and reset cases.
module tb_prime_power_sequencer;
  logic clk = 0, rst_n = 0, start = 0, list_ready = 1, q_ready = 1;
  logic [8:0] bound = 0, list_data, q_data, ld_q;
  logic [12:0] list_index, q_count;
  logic q_valid, busy, done;
  int nerr = 0, nchk = 0;
  int got[$];
  logic [8:0] tbl [0:63];
  int primes [30] = '{2,3,5,7,11,13,17,19,23,29,31,37,41,43,47,53,59,61,67,71,73,79,83,89,97,101,103,107,109,113};
  int seq10 [4] = '{8,9,5,7};

  typedef struct { int b; bit rnd; int n; int idx; } vec_t;
  vec_t vecs [8];

  prime_power_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bound(bound), .list_ready(list_ready),
    .list_index(list_index), .list_data(list_data), .q_valid(q_valid), .q_data(q_data),
    .q_ready(q_ready), .busy(busy), .done(done), .q_count(q_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ld_q <= (list_index < 64) ? tbl[list_index[5:0]] : 9'd0;
  assign list_data = ld_q;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int maxpow(input int p, input int b);
    int q = p;
    while (q * p <= b) q = q * p;
    return q;
  endfunction

  logic prev_stall = 0;
  logic [8:0] prev_d = 0;
  always @(negedge clk) begin
    if (prev_stall && q_valid) chk("stall_stable", q_data, prev_d);
    if (q_valid && q_ready) got.push_back(int'(q_data));
    prev_stall = q_valid && !q_ready;
    prev_d = q_data;
  end

  task automatic do_start(input int b);
    @(posedge clk); #1;
    start = 1; bound = 9'(b);
    @(posedge clk); #1;
    start = 0;
    got.delete();
  endtask

  task automatic run_walk(input bit rnd);
    for (int c = 0; c < 5000 && !done; c++) begin
      @(posedge clk); #1;
      q_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("walk_finished", done, 1);
    q_ready = 1;
  endtask

  task automatic check_walk(input string tag, input int b, input int n, input int idx);
    chk({tag, "_count"}, q_count, n);
    chk({tag, "_index"}, list_index, idx);
    chk({tag, "_nemit"}, got.size(), n);
    chk({tag, "_busy"}, busy, 0);
    for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_q"}, got[i], maxpow(primes[i], b));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tbl[i] = (i >= 1 && i <= 30) ? 9'(primes[i-1]) : 9'd0;
    vecs[0] = '{b:10,  rnd:0, n:4,  idx:5};
    vecs[1] = '{b:1,   rnd:0, n:0,  idx:1};
    vecs[2] = '{b:0,   rnd:0, n:0,  idx:1};
    vecs[3] = '{b:2,   rnd:0, n:1,  idx:2};
    vecs[4] = '{b:100, rnd:1, n:25, idx:26};
    vecs[5] = '{b:4,   rnd:1, n:2,  idx:3};
    vecs[6] = '{b:200, rnd:0, n:30, idx:31};
    vecs[7] = '{b:9,   rnd:1, n:4,  idx:5};
    #12;
    chk("rst_index", list_index, 0);
    chk("rst_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_qdata", q_data, 0);
    rst_n = 1;

    foreach (vecs[v]) begin
      do_start(vecs[v].b);
      run_walk(vecs[v].rnd);
      check_walk($sformatf("vec%0d", v), vecs[v].b, vecs[v].n, vecs[v].idx);
    end

    // B=10: literal sequence and first-emit latency (edge0 start, q_valid after edge 6)
    begin
      int c = 0;
      do_start(10);
      chk("t_busy_edge0", busy, 1);
      chk("t_index_edge0", list_index, 1);
      while (!q_valid && c < 50) begin @(posedge clk); #1; c++; end
      chk("t_first_valid_cycles", c, 6);
      run_walk(0);
      for (int i = 0; i < 4; i++) chk("t_seq10", (i < got.size()) ? got[i] : -1, seq10[i]);
      chk("t_done", done, 1);
    end

    // list_ready low for 1300 cycles after start
    begin
      int bad = 0;
      list_ready = 0;
      do_start(10);
      for (int i = 0; i < 1300; i++) begin
        @(negedge clk);
        if (list_index != 1 || q_valid || !busy) bad++;
      end
      chk("lr_hold_violations", bad, 0);
      list_ready = 1;
      run_walk(0);
      check_walk("lr", 10, 4, 5);
    end

    // mid-walk start with new bound and list_ready drop are ignored; then B=4 from DONE
    begin
      do_start(100);
      repeat (20) @(posedge clk);
      #1; start = 1; bound = 9'd4; list_ready = 0;
      @(posedge clk); #1; start = 0;
      run_walk(1);
      list_ready = 1;
      check_walk("mid", 100, 25, 26);
      chk("mid_first", (got.size() > 0) ? got[0] : -1, 64);
      chk("mid_last", (got.size() > 24) ? got[24] : -1, 97);
      do_start(4);
      run_walk(0);
      check_walk("restart4", 4, 2, 3);
    end

    // async reset during a stalled EMIT
    begin
      int c = 0;
      q_ready = 0;
      do_start(100);
      while (!q_valid && c < 100) begin @(posedge clk); #1; c++; end
      chk("rst_mid_reached_emit", q_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", q_valid, 0);
      chk("arst_qdata", q_data, 0);
      chk("arst_index", list_index, 0);
      chk("arst_busy", busy, 0);
      chk("arst_count", q_count, 0);
      chk("arst_done", done, 0);
      @(posedge clk); #1 rst_n = 1; q_ready = 1;
      do_start(10);
      chk("arst_restart_index", list_index, 1);
      run_walk(0);
      check_walk("arst", 10, 4, 5);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
